riscv_test_monitor: RTL

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

---
 rtl/riscv_test_pkg.sv | 35 +++
 rtl/riscv_test_monitor.sv | 104 ++++++++++
 2 files changed

// File: rtl/riscv_test_pkg.sv
// Shared types and default constants for the RISC-V test monitor.
package riscv_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      VERDICT_NONE,
      VERDICT_PASS,
      VERDICT_FAIL,
      VERDICT_TIMEOUT,
      VERDICT_UNKNOWN
   } verdict_t;

   localparam int unsigned DEFAULT_MAX_CYCLES = 10000;
   localparam logic [31:0] DEFAULT_HALT_INST  = 32'hdead10cc;
   localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'h00c0ffee;
   localparam logic [31:0] DEFAULT_FAIL_MAGIC = 32'hdeaddead;
   localparam logic [4:0]  X10_INDEX          = 5'd10;

   function automatic verdict_t classify_x10(input logic [31:0] value,
                                             input logic [31:0] pass_magic,
                                             input logic [31:0] fail_magic);
      if (value == pass_magic)
         return VERDICT_PASS;
      else if (value == fail_magic)
         return VERDICT_FAIL;
      else
         return VERDICT_UNKNOWN;
   endfunction

endpackage

// File: rtl/riscv_test_monitor.sv
// Watches a RISC-V core's fetch and writeback streams, detects the halt
// instruction or a cycle timeout, and latches a pass/fail/unknown/timeout verdict.
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = DEFAULT_MAX_CYCLES,
   parameter logic [31:0] HALT_INST  = DEFAULT_HALT_INST,
   parameter logic [31:0] PASS_MAGIC = DEFAULT_PASS_MAGIC,
   parameter logic [31:0] FAIL_MAGIC = DEFAULT_FAIL_MAGIC
) (
   input  logic        i_Clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_inst_valid,
   input  logic [31:0] i_inst_data,
   input  logic        i_wb_en,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic        o_fail,
   output logic        o_timeout,
   output logic        o_unknown,
   output logic [31:0] o_cycles,
   output logic [31:0] o_x10
);

   localparam logic [31:0] MAX_CNT = 32'(MAX_CYCLES);

   state_t      state_reg, state_next;
   verdict_t    verdict_reg;
   logic [31:0] cnt_reg;
   logic [31:0] x10_reg;

   logic        in_run;
   logic        x10_write;
   logic        halt_hit;
   logic        timeout_hit;
   logic [31:0] x10_eff;

   assign in_run      = (state_reg == ST_RUN);
   assign x10_write   = i_wb_en && (i_wb_addr == X10_INDEX);
   assign halt_hit    = in_run && i_inst_valid && (i_inst_data == HALT_INST);
   assign timeout_hit = in_run && !halt_hit && (cnt_reg == MAX_CNT);
   // A write to x10 in the halt cycle must be seen by the verdict compare.
   assign x10_eff     = x10_write ? i_wb_data : x10_reg;

   always_ff @(posedge i_Clk or posedge i_reset) begin
      if (i_reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (i_start) state_next = ST_RUN;
         ST_RUN: begin
            if (i_start)
               state_next = ST_RUN;
            else if (halt_hit || timeout_hit)
               state_next = ST_DONE;
         end
         ST_DONE: if (i_start) state_next = ST_RUN;
         default: state_next = ST_IDLE;
      endcase
   end

   // The counter stops on the halt/timeout edge so it reports the final cycle index.
   always_ff @(posedge i_Clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_reg     <= '0;
         x10_reg     <= '0;
         verdict_reg <= VERDICT_NONE;
      end else if (i_start) begin
         cnt_reg     <= '0;
         x10_reg     <= '0;
         verdict_reg <= VERDICT_NONE;
      end else if (in_run) begin
         if (x10_write)
            x10_reg <= i_wb_data;
         if (halt_hit)
            verdict_reg <= classify_x10(x10_eff, PASS_MAGIC, FAIL_MAGIC);
         else if (timeout_hit)
            verdict_reg <= VERDICT_TIMEOUT;
         else if (cnt_reg != '1)
            cnt_reg <= cnt_reg + 32'd1;
      end
   end

   always_comb begin
      o_busy    = (state_reg == ST_RUN);
      o_done    = (state_reg == ST_DONE);
      o_pass    = (verdict_reg == VERDICT_PASS);
      o_fail    = (verdict_reg == VERDICT_FAIL);
      o_timeout = (verdict_reg == VERDICT_TIMEOUT);
      o_unknown = (verdict_reg == VERDICT_UNKNOWN);
      o_cycles  = cnt_reg;
      o_x10     = x10_reg;
   end

endmodule
